// File: rtl/hmc_rf_access_arbiter.sv
// Round-robin arbiter serialising NUM_CH requesters onto the single HMC RF port.
// Optional watchdog on the RF access is enabled by defining RF_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module hmc_rf_access_arbiter #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned HMC_RF_AWIDTH  = 4,
   parameter int unsigned HMC_RF_RWIDTH  = 64,
   parameter int unsigned HMC_RF_WWIDTH  = 64,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              res_n,
   input  logic [NUM_CH-1:0]                 ch_req,
   input  logic [NUM_CH-1:0]                 ch_we,
   input  logic [NUM_CH*HMC_RF_AWIDTH-1:0]   ch_addr,
   input  logic [NUM_CH*HMC_RF_WWIDTH-1:0]   ch_wdata,
   output logic [NUM_CH-1:0]                 ch_ack,
   output logic [HMC_RF_RWIDTH-1:0]          ch_rdata,
   output logic                              ch_invalid,
   output logic                              ch_timeout,
   output logic                              busy,
   output logic [HMC_RF_AWIDTH-1:0]          rf_address,
   output logic                              rf_read_en,
   output logic                              rf_write_en,
   output logic [HMC_RF_WWIDTH-1:0]          rf_write_data,
   input  logic [HMC_RF_RWIDTH-1:0]          rf_read_data,
   input  logic                              rf_invalid_address,
   input  logic                              rf_access_complete
);

   localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              rr_q, rr_d;
   logic [CW-1:0]              grant_q, grant_d;
   logic                       we_q, we_d;
   logic [HMC_RF_AWIDTH-1:0]   addr_q, addr_d;
   logic [HMC_RF_WWIDTH-1:0]   wdata_q, wdata_d;
   logic [HMC_RF_RWIDTH-1:0]   rdata_q, rdata_d;
   logic                       invalid_q, invalid_d;
`ifdef RF_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0]              cnt_q, cnt_d;
   logic                       timeout_q, timeout_d;
`endif

   logic [CW-1:0]              cand;
   logic [CW-1:0]              gnt;
   logic                       gnt_found;

   // First requester strictly after the RR pointer, wrapping modulo NUM_CH.
   always_comb begin
      cand      = '0;
      gnt       = '0;
      gnt_found = 1'b0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand = CW'((32'(rr_q) + i) % NUM_CH);
         if (!gnt_found && ch_req[cand]) begin
            gnt       = cand;
            gnt_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      grant_d   = grant_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      invalid_d = invalid_q;
`ifdef RF_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               grant_d   = gnt;
               rr_d      = gnt;
               we_d      = ch_we[gnt];
               addr_d    = ch_addr[32'(gnt)*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
               wdata_d   = ch_wdata[32'(gnt)*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
               rdata_d   = '0;
               invalid_d = 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
               cnt_d     = '0;
               timeout_d = 1'b0;
`endif
               state_d   = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            // Completion wins over watchdog expiry in the same cycle.
            if (rf_access_complete) begin
               rdata_d   = we_q ? '0 : rf_read_data;
               invalid_d = rf_invalid_address;
               state_d   = RESP;
            end
`ifdef RF_ARB_TIMEOUT_EN
            else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d   = '0;
               invalid_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = RESP;
            end
`endif
            else begin
`ifdef RF_ARB_TIMEOUT_EN
               cnt_d   = cnt_q + TW'(1);
`endif
               state_d = WAIT;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q   <= IDLE;
         rr_q      <= CW'(NUM_CH - 1);
         grant_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         invalid_q <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         invalid_q <= invalid_d;
`ifdef RF_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      ch_ack     = '0;
      ch_rdata   = '0;
      ch_invalid = 1'b0;
      ch_timeout = 1'b0;
      if (state_q == RESP) begin
         ch_ack[grant_q] = 1'b1;
         ch_rdata        = rdata_q;
         ch_invalid      = invalid_q;
`ifdef RF_ARB_TIMEOUT_EN
         ch_timeout      = timeout_q;
`endif
      end
   end

   assign busy          = (state_q != IDLE);
   assign rf_read_en    = (state_q == ISSUE) && !we_q;
   assign rf_write_en   = (state_q == ISSUE) && we_q;
   assign rf_address    = busy ? addr_q : '0;
   assign rf_write_data = busy ? wdata_q : '0;

endmodule

// File: tb/tb_hmc_rf_access_arbiter.sv
// Scoreboard bench for hmc_rf_access_arbiter; define RF_ARB_TIMEOUT_EN to cover the watchdog.
`timescale 1ns/1ps
module tb_hmc_rf_access_arbiter;
   localparam int unsigned NCH = 4;
   localparam int unsigned AW  = 4;
   localparam int unsigned RW  = 64;
   localparam int unsigned WW  = 64;
`ifdef RF_ARB_TIMEOUT_EN
   localparam int unsigned TMO = 8;
`else
   localparam int unsigned TMO = 255;
`endif

   logic              clk = 1'b0;
   logic              res_n = 1'b0;
   logic [NCH-1:0]    ch_req = '0;
   logic [NCH-1:0]    ch_we = '0;
   logic [NCH*AW-1:0] ch_addr = '0;
   logic [NCH*WW-1:0] ch_wdata = '0;
   logic [NCH-1:0]    ch_ack;
   logic [RW-1:0]     ch_rdata;
   logic              ch_invalid, ch_timeout, busy;
   logic [AW-1:0]     rf_address;
   logic              rf_read_en, rf_write_en;
   logic [WW-1:0]     rf_write_data;
   logic [RW-1:0]     rf_read_data = '0;
   logic              rf_invalid_address = 1'b0;
   logic              rf_access_complete = 1'b0;

   hmc_rf_access_arbiter #(
      .NUM_CH(NCH), .HMC_RF_AWIDTH(AW), .HMC_RF_RWIDTH(RW),
      .HMC_RF_WWIDTH(WW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .res_n(res_n), .ch_req(ch_req), .ch_we(ch_we),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack),
      .ch_rdata(ch_rdata), .ch_invalid(ch_invalid), .ch_timeout(ch_timeout),
      .busy(busy), .rf_address(rf_address), .rf_read_en(rf_read_en),
      .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
      .rf_read_data(rf_read_data), .rf_invalid_address(rf_invalid_address),
      .rf_access_complete(rf_access_complete)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned ch;
      logic        we;
      logic [3:0]  addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        inv;
      logic        tmo;
      int unsigned lat;
      logic        gap;
   } exp_t;

   exp_t        sb[$];
   int unsigned vectors = 0, miscompares = 0;
   int unsigned cyc = 0;
   int unsigned issued[NCH] = '{default: 0};
   int unsigned served[NCH] = '{default: 0};
   int unsigned rsp_delay = 0;
   logic        rsp_en = 1'b1;
   int unsigned late_req = 0, late_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Controller model: register contents the RF returns for each address.
   function automatic logic [63:0] rsp_data(input logic [3:0] a);
      case (a)
         4'h5:    return 64'h0123_4567_89AB_CDEF;
         4'h2:    return 64'h2222_0000_0000_2222;
         4'h4:    return 64'h4444_0000_0000_4444;
         4'hF:    return 64'h0;
         default: return 64'hBAD0_0000_0000_00AA;
      endcase
   endfunction

   initial begin : responder
      logic [3:0] a;
      forever begin
         @(negedge clk);
         rf_access_complete = 1'b0;
         rf_read_data       = '0;
         rf_invalid_address = 1'b0;
         if (late_req != late_done) begin
            late_done++;
            rf_access_complete = 1'b1;
            rf_read_data       = 64'hFFFF_0000_FFFF_0000;
            rf_invalid_address = 1'b1;
         end else if (res_n && rsp_en && (rf_read_en || rf_write_en)) begin
            a = rf_address;
            repeat (rsp_delay) @(negedge clk);
            rf_access_complete = 1'b1;
            rf_read_data       = rsp_data(a);
            rf_invalid_address = (a == 4'hF);
         end
      end
   end

   // Requesters keep ch_req high until every issued transaction is acked.
   always @(negedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (res_n && ch_ack[i]) served[i]++;
         ch_req[i] = (issued[i] != served[i]);
      end
   end

   logic        in_txn = 1'b0;
   int unsigned strobe_cyc = 0, last_ack_cyc = 0;
   always @(negedge clk) begin : monitor
      exp_t           e;
      logic [NCH-1:0] oh;
      if (!res_n) begin
         in_txn = 1'b0;
      end else begin
         if (rf_read_en || rf_write_en) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL strobe_unexpected: got access to 0x%0h, expected none", rf_address);
            end else begin
               chk("strobe_both", 64'(rf_read_en & rf_write_en), 64'd0);
               chk("strobe_we", 64'(rf_write_en), 64'(sb[0].we));
               chk("rf_address", 64'(rf_address), 64'(sb[0].addr));
               if (sb[0].we) chk("rf_write_data", rf_write_data, sb[0].wdata);
               if (sb[0].gap) chk("grant_gap", 64'(cyc - last_ack_cyc), 64'd2);
               strobe_cyc = cyc;
               in_txn     = 1'b1;
            end
         end else if (in_txn && sb.size() != 0) begin
            chk("addr_hold", 64'(rf_address), 64'(sb[0].addr));
            chk("busy_in_txn", 64'(busy), 64'd1);
         end
         if (ch_ack != '0) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL ack_unexpected: got ch_ack 0x%0h, expected none", ch_ack);
            end else begin
               e  = sb.pop_front();
               oh = '0;
               oh[e.ch] = 1'b1;
               chk("ch_ack", 64'(ch_ack), 64'(oh));
               chk("ch_rdata", ch_rdata, e.rdata);
               chk("ch_invalid", 64'(ch_invalid), 64'(e.inv));
               chk("ch_timeout", 64'(ch_timeout), 64'(e.tmo));
               chk("ack_latency", 64'(in_txn ? cyc - strobe_cyc : 0), 64'(e.lat));
            end
            last_ack_cyc = cyc;
            in_txn       = 1'b0;
         end else begin
            chk("noack_resp", 64'(ch_rdata) | 64'(ch_invalid) | 64'(ch_timeout), 64'd0);
         end
      end
   end

   task automatic issue(input int unsigned ch, input logic we, input logic [3:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input logic inv,
                        input logic tmo, input int unsigned lat, input logic gap,
                        input logic new_req);
      exp_t e;
      e = '{ch: ch, we: we, addr: a, wdata: wd, rdata: rd, inv: inv, tmo: tmo, lat: lat, gap: gap};
      sb.push_back(e);
      ch_we[ch]              = we;
      ch_addr[ch*AW +: AW]   = a;
      ch_wdata[ch*WW +: WW]  = wd;
      if (new_req) issued[ch]++;
   endtask

   task automatic wait_drain(input string nm);
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d responses outstanding, expected 0", nm, sb.size());
         sb.delete();
      end
      @(negedge clk); #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ack"}, 64'(ch_ack), 64'd0);
      chk({nm, "_resp"}, ch_rdata | 64'(ch_invalid) | 64'(ch_timeout), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_strobes"}, 64'(rf_read_en) | 64'(rf_write_en), 64'd0);
      chk({nm, "_rf_address"}, 64'(rf_address), 64'd0);
      chk({nm, "_rf_write_data"}, rf_write_data, 64'd0);
   endtask

   initial begin : stimulus
      repeat (2) @(negedge clk);
      #1 chk_all_zero("reset");
      #1 res_n = 1'b1;
      @(negedge clk); #1;

      // Ch0 write, complete two cycles after the strobe.
      rsp_delay = 2;
      issue(0, 1'b1, 4'h3, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0, 1'b0, 3, 1'b0, 1'b1);
      wait_drain("ch0_write");

      // Ch2 read, complete in the ISSUE cycle.
      rsp_delay = 0;
      issue(2, 1'b0, 4'h5, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1, 1'b0, 1'b1);
      wait_drain("ch2_read");

      // Ch1 read of an invalid address.
      rsp_delay = 3;
      issue(1, 1'b0, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0, 4, 1'b0, 1'b1);
      wait_drain("ch1_invalid");

      // Ch3 write aborted by reset during WAIT, then served after release.
      rsp_en = 1'b0;
      issue(3, 1'b1, 4'h7, 64'h3333_0000_0000_0333, 64'h0, 1'b0, 1'b0, 2, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
      #1 chk("ch3_busy_before_reset", 64'(busy), 64'd1);
      #1 res_n = 1'b0;
      #1 chk_all_zero("midreset");
      sb.delete();
      rsp_en    = 1'b1;
      rsp_delay = 1;
      issue(3, 1'b1, 4'h7, 64'h3333_0000_0000_0333, 64'h0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
      @(negedge clk); #2 res_n = 1'b1;
      wait_drain("ch3_reissue");

      // All channels request together from reset: grants 0,1,2,3,0.
      #1 res_n = 1'b0;
      @(negedge clk); #2 res_n = 1'b1;
      @(negedge clk); #1;
      rsp_delay = 1;
      issue(0, 1'b1, 4'h1, 64'h1111_0000_0000_1111, 64'h0, 1'b0, 1'b0, 2, 1'b0, 1'b1);
      issue(1, 1'b0, 4'h2, 64'h0, 64'h2222_0000_0000_2222, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      issue(2, 1'b0, 4'h4, 64'h0, 64'h4444_0000_0000_4444, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      issue(3, 1'b1, 4'h6, 64'h6666_0000_0000_6666, 64'h0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      issue(0, 1'b1, 4'h1, 64'h1111_0000_0000_1111, 64'h0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      wait_drain("round_robin");

`ifdef RF_ARB_TIMEOUT_EN
      // No completion: watchdog fires after 8 cycles; a late complete is ignored.
      rsp_en = 1'b0;
      issue(1, 1'b0, 4'h2, 64'h0, 64'h0, 1'b0, 1'b1, 8, 1'b0, 1'b1);
      wait_drain("timeout");
      late_req++;
      repeat (4) begin
         @(negedge clk);
         #1 chk("late_complete_busy", 64'(busy), 64'd0);
      end
      rsp_en = 1'b1;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000 ns");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/hmc_rf_access_arbiter.md
Name: hmc_rf_access_arbiter

Overview:
- Parametrised N-channel front end for the HMC controller register-file (RF) port.
- Serialises read/write requests from NUM_CH independent requesters (host bridge, BIST, debug) onto the single RF port, using round-robin arbitration.
- Returns read data, the invalid-address flag and, optionally, a watchdog timeout status per transaction.
- Sits between the requesters and the controller's rf_* pins, replacing a point-to-point RF connection.

Parameters:
NUM_CH, 4, number of requester channels (1..16)
HMC_RF_AWIDTH, 4, RF address width
HMC_RF_RWIDTH, 64, RF read data width
HMC_RF_WWIDTH, 64, RF write data width
TIMEOUT_CYCLES, 255, watchdog limit in clk cycles (used only with RF_ARB_TIMEOUT_EN; must be >=2)

Ports:
clk  in  1  system clock, all logic rising-edge
res_n  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request, level, held until ch_ack
ch_we  in  NUM_CH  per-channel 1=write 0=read
ch_addr  in  NUM_CH*HMC_RF_AWIDTH  packed addresses, channel i at [i*AW +: AW]
ch_wdata  in  NUM_CH*HMC_RF_WWIDTH  packed write data
ch_ack  out  NUM_CH  one-hot, one-cycle completion pulse
ch_rdata  out  HMC_RF_RWIDTH  read data, valid while any ch_ack bit is 1
ch_invalid  out  1  RF reported invalid address, valid with ch_ack
ch_timeout  out  1  watchdog expired, valid with ch_ack
busy  out  1  arbiter not in IDLE
rf_address  out  HMC_RF_AWIDTH  to controller
rf_read_en  out  1  to controller, one-cycle strobe
rf_write_en  out  1  to controller, one-cycle strobe
rf_write_data  out  HMC_RF_WWIDTH  to controller
rf_read_data  in  HMC_RF_RWIDTH  from controller
rf_invalid_address  in  1  from controller, qualified by rf_access_complete
rf_access_complete  in  1  from controller, one-cycle completion

Behaviour:
- Reset (res_n=0, asynchronous): state=IDLE; all outputs 0; RR pointer=NUM_CH-1, so channel 0 wins first; latched fields=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any ch_req bit is set:
  - Grant the first requesting channel after the RR pointer, searching upward with modulo-NUM_CH wrap.
  - Latch addr, we and wdata of the granted channel; update RR pointer to the grant; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): assert rf_read_en or rf_write_en per latched we; go to WAIT.
- rf_address and rf_write_data are driven from latches from ISSUE through RESP and are stable for the whole access.
- WAIT: hold until rf_access_complete=1.
  - rf_access_complete is also accepted in the ISSUE cycle, in which case WAIT is skipped.
  - On complete: capture rf_read_data (for reads; 0 for writes) and rf_invalid_address; go to RESP.
- RESP (exactly 1 cycle): ch_ack[grant]=1, ch_rdata/ch_invalid/ch_timeout valid; go to IDLE.
  - ch_rdata, ch_invalid and ch_timeout are 0 whenever no ack is asserted.
- Latency: req sampled in IDLE at cycle N -> strobe at N+1 -> ack no earlier than N+2. Back-to-back grants have 1 idle cycle (the RESP->IDLE cycle).
- Fairness: a continuously requesting channel waits at most NUM_CH-1 other transactions.
- Requester drops ch_req after grant: the transaction still completes and ack still pulses.
- New requests arriving during a transaction are held off until IDLE; no queueing beyond the level req.
- rf_access_complete in IDLE or RESP: ignored, no state change.
- NUM_CH=1: arbiter degenerates to a pass-through FSM; RR logic is constant.
- Reset mid-operation: immediate return to IDLE with all outputs 0 and no ack for the aborted transaction. Requesters reissue.

Optional Feature:
RF_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - If it reaches TIMEOUT_CYCLES without complete, go to RESP with ch_timeout=1, ch_rdata=0, ch_invalid=0.
  - Complete in the same cycle as expiry takes priority and yields a normal response.
  - A late complete arriving in IDLE is ignored.
- Undefined: no counter; WAIT is unbounded; ch_timeout tied to 0.

Test Plan:
- Ch0 write, addr=0x3, wdata=0xDEAD_BEEF_0000_0001; complete 2 cycles after strobe -> rf_write_en pulse 1 cycle, rf_address=0x3 held, ch_ack[0] 1 cycle, ch_invalid=0.
- Ch2 read addr=0x5; RF returns 0x0123_4567_89AB_CDEF with complete in the ISSUE cycle -> ack at N+2, ch_rdata=0x0123_4567_89AB_CDEF.
- All 4 channels request simultaneously and continuously from reset -> grant order 0,1,2,3,0; each ack one-hot; exactly 1 idle cycle between grants.
- Ch1 read addr=0xF, RF asserts rf_invalid_address with complete -> ch_ack[1]=1, ch_invalid=1, ch_rdata=0.
- res_n low during WAIT of a ch3 write -> all outputs 0 immediately, no ch_ack[3]; after release, ch3 re-request is served normally.
- With RF_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no complete -> ack after 8 cycles in ISSUE/WAIT, ch_timeout=1; a complete arriving later in IDLE is ignored.
